// File: rtl/serial_add_ctrl_pkg.sv
// Shared definitions for the bit-serial add/subtract sequencer:
// FSM state encodings, the ADD/SUB opcode seen by the ALU decoder,
// and a helper that sizes the bit counter.
package serial_add_ctrl_pkg;

  // Sequencer states: accept in IDLE, one bit per cycle in RUN, one-cycle DONE pulse
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // Operation select as driven by the ALU function decoder on the sub line
  typedef enum logic {
    OP_ADD = 1'b0,
    OP_SUB = 1'b1
  } addsub_op_t;

  localparam int DEFAULT_WIDTH = 4;

  // Counter width able to index bits 0..width-1 (at least one bit)
  function automatic int cnt_width(input int width);
    return (width <= 2) ? 1 : $clog2(width);
  endfunction

endpackage

// File: rtl/serial_add_ctrl_if.sv
// Start/busy/done handshake plus operand and result bus between the ALU
// function decoder (master) and the serial add/subtract sequencer (slave).
interface serial_add_ctrl_if
  import serial_add_ctrl_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) ();

  logic             start;
  logic             sub;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             cout;
  logic             ovf;

  modport master (
    output start, sub, a, b,
    input  busy, done, result, cout, ovf
  );

  modport slave (
    input  start, sub, a, b,
    output busy, done, result, cout, ovf
  );

endinterface

// File: rtl/serial_add_ctrl_fulladder.sv
// One-bit full adder cell, time-shared by the serial sequencer.
module fulladder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic cout,
  output logic s
);

  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial add/subtract sequencer. One full adder processes the operands
// LSB first over WIDTH cycles; subtraction is a + ~b + 1 with the +1 entering
// as the initial carry. Result, carry-out and signed overflow are latched on
// entry to DONE and held until the next accepted operation completes.
module serial_add_ctrl
  import serial_add_ctrl_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic            clk,
  input  logic            rst,
  serial_add_ctrl_if.slave bus
);

  localparam int            CW          = cnt_width(WIDTH);
  localparam int            SW          = WIDTH - 1;
  localparam logic [CW-1:0] CNT_LAST    = CW'(WIDTH - 1);
  localparam logic [CW-1:0] CNT_MSB_IN  = CW'(WIDTH - 2);
  localparam logic [CW-1:0] CNT_ONE     = CW'(1);

  state_t           state_reg,  state_next;
  logic [WIDTH-1:0] opa_reg,    opa_next;
  logic [WIDTH-1:0] opb_reg,    opb_next;
  logic             carry_reg,  carry_next;
  logic             c_msb_reg,  c_msb_next;
  logic [CW-1:0]    cnt_reg,    cnt_next;
  // Lower WIDTH-1 sum bits; the MSB is taken straight from the adder on the last cycle
  logic [SW-1:0]    sum_reg,    sum_next;
  logic [WIDTH-1:0] result_reg, result_next;
  logic             cout_reg,   cout_next;
  logic             ovf_reg,    ovf_next;

  logic             fa_s;
  logic             fa_cout;

  fulladder u_fa (
    .a    (opa_reg[0]),
    .b    (opb_reg[0]),
    .cin  (carry_reg),
    .cout (fa_cout),
    .s    (fa_s)
  );

  // Next-state and datapath update: accept in IDLE, shift one bit per RUN cycle,
  // latch the outputs on the transition into DONE
  always_comb begin
    state_next  = state_reg;
    opa_next    = opa_reg;
    opb_next    = opb_reg;
    carry_next  = carry_reg;
    c_msb_next  = c_msb_reg;
    cnt_next    = cnt_reg;
    sum_next    = sum_reg;
    result_next = result_reg;
    cout_next   = cout_reg;
    ovf_next    = ovf_reg;

    case (state_reg)
      S_IDLE: begin
        if (bus.start) begin
          opa_next   = bus.a;
          opb_next   = (addsub_op_t'(bus.sub) == OP_SUB) ? ~bus.b : bus.b;
          carry_next = bus.sub;
          cnt_next   = '0;
          state_next = S_RUN;
        end
      end

      S_RUN: begin
        opa_next   = opa_reg >> 1;
        opb_next   = opb_reg >> 1;
        carry_next = fa_cout;
        sum_next   = SW'({fa_s, sum_reg} >> 1);
        cnt_next   = cnt_reg + CNT_ONE;
        // Carry out of bit WIDTH-2 is the carry into the MSB
        if (cnt_reg == CNT_MSB_IN) begin
          c_msb_next = fa_cout;
        end
        if (cnt_reg == CNT_LAST) begin
          result_next = {fa_s, sum_reg};
          cout_next   = fa_cout;
          ovf_next    = c_msb_reg ^ fa_cout;
          state_next  = S_DONE;
        end
      end

      S_DONE: begin
        state_next = S_IDLE;
      end

      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous reset (aborts any operation)
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg  <= S_IDLE;
      opa_reg    <= '0;
      opb_reg    <= '0;
      carry_reg  <= 1'b0;
      c_msb_reg  <= 1'b0;
      cnt_reg    <= '0;
      sum_reg    <= '0;
      result_reg <= '0;
      cout_reg   <= 1'b0;
      ovf_reg    <= 1'b0;
    end else begin
      state_reg  <= state_next;
      opa_reg    <= opa_next;
      opb_reg    <= opb_next;
      carry_reg  <= carry_next;
      c_msb_reg  <= c_msb_next;
      cnt_reg    <= cnt_next;
      sum_reg    <= sum_next;
      result_reg <= result_next;
      cout_reg   <= cout_next;
      ovf_reg    <= ovf_next;
    end
  end

  assign bus.busy   = (state_reg == S_RUN);
  assign bus.done   = (state_reg == S_DONE);
  assign bus.result = result_reg;
  assign bus.cout   = cout_reg;
  assign bus.ovf    = ovf_reg;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Bench for serial_add_ctrl (WIDTH=4): directed cases, an ignored start during
// RUN, reset abort, back-to-back starts, and all 512 (a, b, sub) combinations
// in random order with operands scrambled after acceptance.
module tb_serial_add_ctrl;

  localparam int W = 4;
  localparam int M = 2 ** W;

  logic clk;
  logic rst;
  int   vectors     = 0;
  int   miscompares = 0;

  serial_add_ctrl_if #(.WIDTH(W)) bus ();

  serial_add_ctrl #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: {ovf, cout, result} from unsigned and signed integer arithmetic
  function automatic logic [W+1:0] model(input logic [W-1:0] ma, input logic [W-1:0] mb,
                                         input logic ms);
    int ua = int'(ma);
    int ub = int'(mb);
    int sa = ma[W-1] ? ua - M : ua;
    int sb = mb[W-1] ? ub - M : ub;
    int ur;
    int sr;
    logic c;
    logic v;
    logic [W-1:0] r;
    if (ms) begin
      ur = ua - ub;
      c  = (ua >= ub);
      sr = sa - sb;
    end else begin
      ur = ua + ub;
      c  = (ur >= M);
      sr = sa + sb;
    end
    r = W'(((ur % M) + M) % M);
    v = (sr > (M / 2 - 1)) || (sr < -(M / 2));
    return {v, c, r};
  endfunction

  task automatic wait_idle();
    int guard = 0;
    while ((bus.busy || bus.done) && guard < 40) begin
      tick();
      guard++;
    end
    if (guard >= 40) check("idle_timeout", 32'(guard), 0);
  endtask

  // Run one operation; optionally scramble inputs during RUN or pulse a second start
  task automatic run_op(input logic [W-1:0] oa, input logic [W-1:0] ob, input logic os,
                        input bit scramble, input bit inject);
    logic [W+1:0] exp;
    logic [W-1:0] prev_res;
    int lat;
    int busy_n;
    int held_bad;
    string tag;
    wait_idle();
    prev_res  = bus.result;
    bus.a     = oa;
    bus.b     = ob;
    bus.sub   = os;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    lat = 1;
    busy_n = 0;
    held_bad = 0;
    while (!bus.done && lat < 20) begin
      if (bus.busy) busy_n++;
      if (bus.result !== prev_res) held_bad++;
      if (inject && lat == 3) begin
        bus.start = 1'b1;
        bus.a     = oa + W'(3);
        bus.b     = ~ob;
        bus.sub   = ~os;
      end else begin
        bus.start = 1'b0;
        if (scramble) begin
          bus.a   = W'($urandom);
          bus.b   = W'($urandom);
          bus.sub = 1'($urandom);
        end
      end
      tick();
      lat++;
    end
    bus.start = 1'b0;
    exp = model(oa, ob, os);
    tag = $sformatf("a=%0d b=%0d sub=%0d", oa, ob, os);
    check({tag, " latency"}, 32'(lat), 32'(W + 1));
    check({tag, " busy_cycles"}, 32'(busy_n), 32'(W));
    check({tag, " hold"}, 32'(held_bad), 0);
    check({tag, " result"}, 32'(bus.result), 32'(exp[W-1:0]));
    check({tag, " cout"}, 32'(bus.cout), 32'(exp[W]));
    check({tag, " ovf"}, 32'(bus.ovf), 32'(exp[W+1]));
  endtask

  initial begin
    logic [W-1:0] da [6] = '{4'd3, 4'd15, 4'd7, 4'd5, 4'd3, 4'd8};
    logic [W-1:0] db [6] = '{4'd5, 4'd1,  4'd7, 4'd3, 4'd5, 4'd1};
    logic         ds [6] = '{1'b0, 1'b0,  1'b0, 1'b1, 1'b1, 1'b1};
    int order [512];
    int extra;
    int n_done;
    int last;

    rst = 1'b1;
    bus.start = 1'b0;
    bus.sub = 1'b0;
    bus.a = '0;
    bus.b = '0;
    tick();
    tick();
    rst = 1'b0;
    check("reset busy", 32'(bus.busy), 0);
    check("reset done", 32'(bus.done), 0);
    check("reset result", 32'(bus.result), 0);
    check("reset cout", 32'(bus.cout), 0);
    check("reset ovf", 32'(bus.ovf), 0);

    // Directed cases
    for (int i = 0; i < 6; i++) run_op(da[i], db[i], ds[i], 1'b0, 1'b0);

    // Second start during RUN is ignored: one done, original result
    run_op(4'd3, 4'd5, 1'b0, 1'b0, 1'b1);
    extra = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (bus.done) extra++;
    end
    check("ignored_start extra_done", 32'(extra), 0);

    // Reset mid-RUN aborts with no done pulse
    bus.a = 4'd7;
    bus.b = 4'd7;
    bus.sub = 1'b0;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("abort busy", 32'(bus.busy), 0);
    check("abort done", 32'(bus.done), 0);
    check("abort result", 32'(bus.result), 0);
    check("abort cout", 32'(bus.cout), 0);
    check("abort ovf", 32'(bus.ovf), 0);
    extra = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (bus.done) extra++;
    end
    check("abort extra_done", 32'(extra), 0);
    run_op(4'd5, 4'd3, 1'b1, 1'b0, 1'b0);

    // start held high: a new op every W+2 cycles
    wait_idle();
    bus.a = 4'd1;
    bus.b = 4'd1;
    bus.sub = 1'b0;
    bus.start = 1'b1;
    n_done = 0;
    last = -1;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (bus.done) begin
        n_done++;
        if (last >= 0) check("stream spacing", 32'(i - last), 32'(W + 2));
        else check("stream first_latency", 32'(i), 32'(W + 1));
        last = i;
        check("stream result", 32'(bus.result), 2);
        check("stream cout", 32'(bus.cout), 0);
        check("stream ovf", 32'(bus.ovf), 0);
      end
    end
    bus.start = 1'b0;
    check("stream done_count", 32'(n_done), 3);
    for (int i = 0; i < 8; i++) tick();

    // Exhaustive sweep in shuffled order with random idle gaps
    for (int i = 0; i < 512; i++) order[i] = i;
    for (int i = 511; i > 0; i--) begin
      int j;
      int t;
      j = int'($urandom_range(i, 0));
      t = order[i];
      order[i] = order[j];
      order[j] = t;
    end
    for (int i = 0; i < 512; i++) begin
      logic [8:0] v;
      v = 9'(order[i]);
      for (int g = int'($urandom_range(2, 0)); g > 0; g--) tick();
      run_op(v[3:0], v[7:4], v[8], 1'b1, 1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
